// File: rtl/mul_arbiter.sv
// mul_arbiter: two requesters share one combinational 16x16 signed multiplier.
// Round-robin grant in IDLE, operand capture, one multiply cycle (CALC), then
// the product is held (HOLD) until the consumer takes it.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid/a/b/ready       requester N operand handshake (N = 0,1)
//   out_valid/ready            product handshake
//   out_id                     requester that owns out_prod
//   out_prod                   32-bit signed product
//   grant_cnt0/1               accepted-request counters (only when the
//                              MUL_ARB_STATS_EN macro is defined)
//
// Parameter
//   CNT_W                      width of the grant counters
module mul_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic signed [15:0]       req0_a,
  input  logic signed [15:0]       req0_b,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic signed [15:0]       req1_a,
  input  logic signed [15:0]       req1_b,
  output logic                     req1_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_id,
  output logic signed [31:0]       out_prod
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]         grant_cnt0,
  output logic [CNT_W-1:0]         grant_cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("mul_arbiter: CNT_W must be at least 1");
  end

  state_t             r_state;
  logic               r_last;   // requester granted most recently
  logic signed [15:0] r_a, r_b;
  logic               r_id;

  logic               w_any;
  logic               w_gnt;
  logic               w_hs;
  logic signed [15:0] w_a, w_b;
  logic signed [31:0] w_prod;

  assign w_any = req0_valid | req1_valid;

  // Tie goes to whoever was not served last; otherwise the lone requester.
  always_comb begin
    w_gnt = req1_valid;
    if (req0_valid && req1_valid) w_gnt = ~r_last;
  end

  // In IDLE the granted requester is always valid, so ready implies handshake.
  assign w_hs       = rst_n && (r_state == S_IDLE) && w_any;
  assign req0_ready = w_hs && !w_gnt;
  assign req1_ready = w_hs &&  w_gnt;

  assign w_a = w_gnt ? req1_a : req0_a;
  assign w_b = w_gnt ? req1_b : req0_b;

  // Shared multiplier sees only the captured operands.
  assign w_prod = r_a * r_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= 1'b0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_id    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_id    <= w_gnt;
            r_last  <= w_gnt;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          out_prod  <= w_prod;
          out_id    <= r_id;
          out_valid <= 1'b1;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MUL_ARB_STATS_EN
  // Free-running counters, wrap naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;
`ifdef MUL_ARB_STATS_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic signed [15:0] req0_a, req0_b, req1_a, req1_b;
  logic out_valid, out_ready, out_id;
  logic signed [31:0] out_prod;
`ifdef MUL_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  mul_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_prod(out_prod)
`ifdef MUL_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: "busy" with an age counted from the accepting edge;
  // the product is visible from age 1 until the consumer takes it.
  logic rst_drv;
  bit   m_busy;
  int   m_age;
  bit   m_id;
  bit   m_last;
  bit   m_any, m_g;
  logic signed [31:0] m_prod;
  int   m_cnt[2];
  int   hs_cnt[2];
  int   glog[$];

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic [31:0]        exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_chk(input logic v0, input logic signed [15:0] a0, input logic signed [15:0] b0,
                           input logic v1, input logic signed [15:0] a1, input logic signed [15:0] b1,
                           input logic ordy);
    bit e_free;
    @(negedge clk);
    rst_n = rst_drv;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    out_ready = ordy;
    #1;
    m_any = v0 | v1;
    if (v0 && v1) m_g = !m_last;
    else          m_g = v1;
    e_free = rst_n && !m_busy && m_any;
    chk("req0_ready", req0_ready, e_free && !m_g);
    chk("req1_ready", req1_ready, e_free && m_g);
    chk("out_valid", out_valid, m_busy && m_age >= 1);
    if (m_busy && m_age >= 1) begin
      chk("out_prod", out_prod, m_prod);
      chk("out_id", out_id, m_id);
    end
`ifdef MUL_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0, m_cnt[0] % (1 << CNT_W));
    chk("grant_cnt1", grant_cnt1, m_cnt[1] % (1 << CNT_W));
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (!m_busy) begin
      if (m_any) begin
        m_busy = 1; m_age = 0; m_id = m_g; m_last = m_g;
        m_prod = m_g ? int'(req1_a) * int'(req1_b) : int'(req0_a) * int'(req0_b);
        m_cnt[m_g]++; hs_cnt[m_g]++;
        glog.push_back(int'(m_g));
      end
    end else if (m_age >= 1 && out_ready) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic cyc(input logic v0, input logic signed [15:0] a0, input logic signed [15:0] b0,
                     input logic v1, input logic signed [15:0] a1, input logic signed [15:0] b1,
                     input logic ordy);
    drive_chk(v0, a0, b0, v1, a1, b1, ordy);
    adv();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Two reset cycles with both requesters asking: readies must stay low.
  task automatic do_reset();
    rst_drv = 0;
    cyc(1, 5, 5, 1, 6, 6, 1);
    cyc(1, 5, 5, 1, 6, 6, 1);
    rst_drv = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [15:0] ra0, rb0, ra1, rb1;
    logic [31:0] bp_prod;
    int budget;

    tbl[0] = '{a: -16'sd32768, b: -16'sd32768, exp: 32'h40000000};
    tbl[1] = '{a: -16'sd32768, b:  16'sd32767, exp: -32'sd1073709056};
    tbl[2] = '{a:  16'sd0,     b: -16'sd1,     exp: 32'd0};
    tbl[3] = '{a:  16'sd32767, b:  16'sd32767, exp: 32'h3FFF0001};
    tbl[4] = '{a: -16'sd1,     b: -16'sd1,     exp: 32'd1};
    tbl[5] = '{a:  16'sd12345, b: -16'sd2,     exp: -32'sd24690};
    tbl[6] = '{a:  16'sd3,     b: -16'sd7,     exp: -32'sd21};

    rst_drv = 0; rst_n = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0;
    out_ready = 0;
    m_busy = 0; m_age = 0; m_id = 0; m_last = 1; m_prod = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; hs_cnt[0] = 0; hs_cnt[1] = 0;

    do_reset();
    drive_chk(0, 0, 0, 0, 0, 0, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_prod", out_prod, 0);
    chk("rst_out_id", out_id, 0);
    adv();

    // Single request, product two cycles after the accepting cycle.
    drive_chk(1, 3, -7, 0, 0, 0, 1);
    chk("single_ready0", req0_ready, 1);
    adv();
    drive_chk(0, 0, 0, 0, 0, 0, 1);
    chk("single_calc_valid", out_valid, 0);
    adv();
    drive_chk(0, 0, 0, 0, 0, 0, 1);
    chk("single_valid", out_valid, 1);
    chk("single_prod", out_prod, -32'sd21);
    chk("single_id", out_id, 0);
    adv();
    idle(1);

    // Operand table, including the extremes.
    for (int i = 0; i < 7; i++) begin
      cyc(1, tbl[i].a, tbl[i].b, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      drive_chk(0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("tbl%0d_prod", i), out_prod, tbl[i].exp);
      adv();
    end

    // Contention from reset: grants alternate starting with requester 0.
    do_reset();
    glog.delete();
    for (int i = 0; i < 12; i++) begin
      ra0 = 16'($urandom); rb0 = 16'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      cyc(1, ra0, rb0, 1, ra1, rb1, 1);
    end
    chk("contention_count", glog.size() >= 4, 1);
    if (glog.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("contention_gnt%0d", k), glog[k], k % 2);
    idle(3);

    // Backpressure: product held for 5 cycles while both requesters wait.
    cyc(1, 100, -3, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 2, 2, 0);
    bp_prod = out_prod;
    for (int i = 0; i < 5; i++) begin
      drive_chk(1, 1, 1, 1, 2, 2, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_prod", out_prod, -32'sd300);
      chk("bp_id", out_id, 0);
      chk("bp_readies", {req0_ready, req1_ready}, 0);
      adv();
    end
    drive_chk(0, 0, 0, 0, 0, 0, 1);
    chk("bp_take_valid", out_valid, 1);
    adv();
    drive_chk(0, 0, 0, 0, 0, 0, 1);
    chk("bp_done_valid", out_valid, 0);
    adv();
    idle(2);

    // Reset while the multiply is in flight.
    cyc(0, 0, 0, 1, 7, 8, 1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_chk(0, 0, 0, 0, 0, 0, 1);
      chk("rstmid_no_valid", out_valid, 0);
      adv();
    end
    drive_chk(1, 2, 2, 1, 3, 3, 1);
    chk("rstmid_tie_ready0", req0_ready, 1);
    chk("rstmid_tie_ready1", req1_ready, 0);
    adv();
    idle(3);

`ifdef MUL_ARB_STATS_EN
    // Five requester-1 grants wrap a 2-bit counter to 1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 16'(i), 9, 1);
      idle(2);
    end
    drive_chk(0, 0, 0, 0, 0, 0, 1);
    chk("stats_cnt1_wrap", grant_cnt1, 1);
    chk("stats_cnt0", grant_cnt0, 0);
    adv();
`endif

    // Random traffic until each requester has at least 100 accepted pairs.
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    budget = 0;
    while ((hs_cnt[0] < 100 || hs_cnt[1] < 100) && budget < 4000) begin
      ra0 = 16'($urandom); rb0 = 16'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ra0 = -16'sd32768;
      if ($urandom_range(0, 15) == 0) rb1 = 16'sd32767;
      cyc($urandom_range(0, 3) != 0, ra0, rb0, $urandom_range(0, 3) != 0, ra1, rb1,
          $urandom_range(0, 3) != 0);
      budget++;
    end
    chk("random_hs0_ge100", hs_cnt[0] >= 100, 1);
    chk("random_hs1_ge100", hs_cnt[1] >= 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
